trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Consumes exception requests from the exception detector and mret from decode. Commits machine trap CSRs
//  (mepc, mcause, mtval, mstatus.MIE/MPIE, mtvec) and drains the pipeline for FLUSH_CYCLES.
//  Issues a single-cycle PC redirect to fetch: the trap vector on an exception, mepc on mret.
//  Sits between the exception detector / decode and the PC register.
// PARAMETERS
//  XLEN          32            data/address width
//  RESET_MTVEC   32'h0000_0004 mtvec value after reset (trap handler base)
//  FLUSH_CYCLES  2             cycles flush is held before redirect; legal range 1..15
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous active-high reset
//  exc_valid     in   1     exception request, qualified 1 cycle
//  exc_code      in   XLEN  cause code, stored verbatim into mcause
//  exc_pc        in   XLEN  PC of faulting instruction
//  exc_tval      in   XLEN  trap value (faulting address)
//  mret_valid    in   1     mret retiring, qualified 1 cycle
//  csr_we        in   1     CSR write strobe
//  csr_addr      in   12    CSR address (read and write)
//  csr_wdata     in   XLEN  CSR write data
//  csr_rdata     out  XLEN  combinational read of csr_addr; 0 for unmapped addresses
//  flush         out  1     kill all in-flight instructions
//  stall         out  1     hold fetch/decode; high whenever FSM is not IDLE
//  redirect_valid out 1     1-cycle pulse: load redirect_pc into PC
//  redirect_pc   out  XLEN  target PC, valid with redirect_valid
// BEHAVIOUR
//  Reset: FSM=IDLE, flush=stall=redirect_valid=0, redirect_pc=0, mtvec=RESET_MTVEC, mepc=mcause=mtval=0,
//    MIE=0, MPIE=1. Reset mid-drain aborts the drain and produces no redirect.
//  FSM IDLE -> DRAIN -> REDIRECT -> IDLE.
//  IDLE + exc_valid, registered on that edge:
//    - mepc<=exc_pc & ~3; mcause<=exc_code; mtval<=exc_tval; MPIE<=MIE; MIE<=0
//    - tgt<={mtvec[31:2],2'b00}; cnt<=FLUSH_CYCLES-1; -> DRAIN
//  IDLE + mret_valid (no exc_valid): MIE<=MPIE; MPIE<=1; tgt<=mepc; cnt<=FLUSH_CYCLES-1; -> DRAIN.
//  exc_valid and mret_valid in the same cycle: the exception wins and the mret is discarded.
//  DRAIN: flush=1, stall=1; cnt decrements each cycle; at cnt==0 -> REDIRECT.
//    flush is therefore high exactly FLUSH_CYCLES cycles.
//  REDIRECT: redirect_valid=1, redirect_pc=tgt, flush=0, stall=1; next -> IDLE.
//  Latency: exc_valid at cycle T -> redirect_valid at cycle T+1+FLUSH_CYCLES.
//  exc_valid/mret_valid while not IDLE: ignored (upstream is stalled); no CSR side effects.
//  CSR writes:
//    - mtvec[1:0] and mepc[1:0] forced to 00 (direct mode only); mcause and mtval are stored as written.
//    - mstatus write updates only MIE(bit 3) and MPIE(bit 7); all other mstatus bits read 0.
//    - csr_we coinciding with trap/mret entry: the hardware update wins for the affected fields;
//      csr_we to unaffected CSRs proceeds.
//    - csr_we while not IDLE is ignored.
//  csr_rdata reflects state after the last clock edge; no read-during-write bypass.
// STRUCTURE
//  Shared package trap_pkg:
//    - CSR address constants: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343
//    - FSM state typedef; mstatus bit indices MIE_BIT=3, MPIE_BIT=7
//  One natural sub-module: trap_csr_file, holding the CSR registers, write masking, read mux and
//    trap/mret update ports. The FSM and counter stay in trap_controller.
// TESTING
//  1 exc_valid, exc_code=2, exc_pc=32'h100, exc_tval=32'h102, MIE=1 -> mcause=2, mepc=32'h100,
//    mtval=32'h102, MIE=0, MPIE=1; flush high 2 cycles; redirect_pc=32'h4 at T+3.
//  2 write mtvec=32'h2003, then an exception -> mtvec reads 32'h2000; redirect_pc=32'h2000.
//  3 after test 1, mret_valid -> redirect_pc=32'h100 at T+3; MIE=1, MPIE=1.
//  4 exc_valid and mret_valid in the same cycle -> trap taken to mtvec; mepc updated; MIE=0;
//    exactly one redirect.
//  5 second exc_valid during DRAIN with exc_pc=32'h200 -> mepc stays 32'h100; one redirect only.
//  6 rst asserted during DRAIN cycle 1 -> no redirect_valid; all outputs and CSRs at reset values next cycle.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// mstatus bit positions and the controller state encoding.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT
    } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine trap CSRs (mstatus.MIE/MPIE, mtvec, mepc, mcause, mtval) with
// software write masking, combinational read mux and trap/mret update ports.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_en,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mstatus;

    always_comb begin
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        if (csr_we) begin
            case (csr_addr)
                CSR_MTVEC:   mtvec_d  = csr_wdata & ALIGN_MASK;
                CSR_MEPC:    mepc_d   = csr_wdata & ALIGN_MASK;
                CSR_MCAUSE:  mcause_d = csr_wdata;
                CSR_MTVAL:   mtval_d  = csr_wdata;
                CSR_MSTATUS: begin
                    mie_d  = csr_wdata[MIE_BIT];
                    mpie_d = csr_wdata[MPIE_BIT];
                end
                default: ;
            endcase
        end
        // Hardware updates come last so they override a coincident software write.
        if (trap_en) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_en) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_q  <= RESET_MTVEC;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b1;
        end else begin
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    always_comb begin
        mstatus           = '0;
        mstatus[MIE_BIT]  = mie_q;
        mstatus[MPIE_BIT] = mpie_q;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MTVAL:   csr_rdata = mtval_q;
            default:     csr_rdata = '0;
        endcase
    end

    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;

endmodule

// File: rtl/trap_controller.sv
// Trap/mret sequencer: commits trap CSRs, drains the pipeline for FLUSH_CYCLES
// and then issues a one-cycle PC redirect to the trap vector or mepc.
module trap_controller
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC  = 32'h0000_0004,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [3:0]      CNT_INIT   = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    trap_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            idle;
    logic            take_trap;
    logic            take_mret;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    assign idle      = (state_q == ST_IDLE);
    assign take_trap = idle && exc_valid;
    assign take_mret = idle && mret_valid && !exc_valid;

    trap_csr_file #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (csr_we && idle),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .trap_en    (take_trap),
        .trap_pc    (exc_pc),
        .trap_cause (exc_code),
        .trap_tval  (exc_tval),
        .mret_en    (take_mret),
        .mtvec      (mtvec),
        .mepc       (mepc)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tgt_d          = tgt_q;
        flush          = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            ST_IDLE: begin
                stall = 1'b0;
                if (take_trap) begin
                    tgt_d   = mtvec & ALIGN_MASK;
                    cnt_d   = CNT_INIT;
                    state_d = ST_DRAIN;
                end else if (take_mret) begin
                    tgt_d   = mepc;
                    cnt_d   = CNT_INIT;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-count reference model.
module tb_trap_controller;

    localparam int unsigned F = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret_valid = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_controller #(
        .XLEN         (32),
        .RESET_MTVEC  (32'h0000_0004),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: CSR values plus "cycles since the trap/mret was accepted"
    // (0 = idle, 1..F = draining, F+1 = redirect cycle).
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_tgt;
    logic        m_mie, m_mpie;
    int          m_since = 0;
    bit          m_valid = 0;

    logic        last_flush, last_stall, last_rv;
    logic [31:0] last_rpc, last_rdata;
    int          n_redirects = 0;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtvec  = 32'h4;
        m_mepc   = '0;
        m_mcause = '0;
        m_mtval  = '0;
        m_mie    = 1'b0;
        m_mpie   = 1'b1;
        m_tgt    = '0;
        m_since  = 0;
        m_valid  = 1;
    endtask

    task automatic step(input logic r, input logic e, input logic [31:0] code,
                        input logic [31:0] pc, input logic [31:0] tval, input logic m,
                        input logic w, input logic [11:0] a, input logic [31:0] wd);
        logic [31:0] old_mtvec, old_mepc;
        logic        old_mie, old_mpie;
        @(negedge clk);
        rst = r; exc_valid = e; exc_code = code; exc_pc = pc; exc_tval = tval;
        mret_valid = m; csr_we = w; csr_addr = a; csr_wdata = wd;
        #1;
        last_flush = flush; last_stall = stall; last_rv = redirect_valid;
        last_rpc = redirect_pc; last_rdata = csr_rdata;
        if (redirect_valid === 1'b1) n_redirects++;
        if (m_valid) begin
            check_eq("csr_rdata", csr_rdata, model_read(a));
            check_eq("flush", {31'b0, flush}, {31'b0, (m_since >= 1 && m_since <= F)});
            check_eq("stall", {31'b0, stall}, {31'b0, (m_since != 0)});
            check_eq("redirect_valid", {31'b0, redirect_valid}, {31'b0, (m_since == F + 1)});
            check_eq("redirect_pc", redirect_pc, (m_since == F + 1) ? m_tgt : 32'h0);
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (m_valid) begin
            if (m_since == 0) begin
                old_mtvec = m_mtvec; old_mepc = m_mepc; old_mie = m_mie; old_mpie = m_mpie;
                if (w) begin
                    case (a)
                        12'h305: m_mtvec  = wd & ~32'h3;
                        12'h341: m_mepc   = wd & ~32'h3;
                        12'h342: m_mcause = wd;
                        12'h343: m_mtval  = wd;
                        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
                        default: ;
                    endcase
                end
                if (e) begin
                    m_mepc = pc & ~32'h3; m_mcause = code; m_mtval = tval;
                    m_mpie = old_mie; m_mie = 1'b0;
                    m_tgt = old_mtvec & ~32'h3; m_since = 1;
                end else if (m) begin
                    m_mie = old_mpie; m_mpie = 1'b1;
                    m_tgt = old_mepc; m_since = 1;
                end
            end else begin
                m_since = (m_since == F + 1) ? 0 : m_since + 1;
            end
        end
    endtask

    task automatic idle(input logic [11:0] a);
        step(0, 0, '0, '0, '0, 0, 0, a, '0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] wd);
        step(0, 0, '0, '0, '0, 0, 1, a, wd);
    endtask

    int          flush_cnt;
    int          rd_base;
    logic [11:0] ra;
    logic [31:0] rpc;

    initial begin
        step(1, 0, '0, '0, '0, 0, 0, 12'h305, '0);
        step(1, 0, '0, '0, '0, 0, 0, 12'h305, '0);
        idle(12'h305);
        check_eq("rst_mtvec", last_rdata, 32'h4);
        check_eq("rst_outputs", {28'b0, last_flush, last_stall, last_rv, 1'b0}, 32'h0);
        idle(12'h300);
        check_eq("rst_mstatus", last_rdata, 32'h80);

        // 1: exception with MIE=1
        csr_write(12'h300, 32'h8);
        step(0, 1, 32'h2, 32'h100, 32'h102, 0, 0, 12'h342, '0);
        flush_cnt = 0;
        idle(0); flush_cnt += int'(last_flush);
        idle(0); flush_cnt += int'(last_flush);
        idle(0); flush_cnt += int'(last_flush);
        check_eq("t1_flush_cycles", flush_cnt, F);
        check_eq("t1_redirect_valid", {31'b0, last_rv}, 32'h1);
        check_eq("t1_redirect_pc", last_rpc, 32'h4);
        idle(12'h342); check_eq("t1_mcause", last_rdata, 32'h2);
        idle(12'h341); check_eq("t1_mepc", last_rdata, 32'h100);
        idle(12'h343); check_eq("t1_mtval", last_rdata, 32'h102);
        idle(12'h300); check_eq("t1_mstatus", last_rdata, 32'h80);

        // 3: mret back to mepc
        step(0, 0, '0, '0, '0, 1, 0, 12'h0, '0);
        idle(0); idle(0); idle(0);
        check_eq("t3_redirect_pc", last_rpc, 32'h100);
        idle(12'h300); check_eq("t3_mstatus", last_rdata, 32'h88);

        // 2: misaligned mtvec write
        csr_write(12'h305, 32'h2003);
        idle(12'h305); check_eq("t2_mtvec", last_rdata, 32'h2000);
        step(0, 1, 32'h5, 32'h300, 32'h0, 0, 0, 12'h0, '0);
        idle(0); idle(0); idle(0);
        check_eq("t2_redirect_pc", last_rpc, 32'h2000);

        // 5: second exception during drain is ignored
        rd_base = n_redirects;
        step(0, 1, 32'h7, 32'h100, 32'h0, 0, 0, 12'h0, '0);
        step(0, 1, 32'h9, 32'h200, 32'h0, 0, 0, 12'h0, '0);
        idle(0); idle(0); idle(0); idle(0);
        check_eq("t5_one_redirect", n_redirects - rd_base, 1);
        idle(12'h341); check_eq("t5_mepc", last_rdata, 32'h100);

        // 4: exception and mret together
        csr_write(12'h300, 32'h8);
        rd_base = n_redirects;
        step(0, 1, 32'hb, 32'h400, 32'h0, 1, 0, 12'h0, '0);
        idle(0); idle(0); idle(0);
        check_eq("t4_redirect_pc", last_rpc, 32'h2000);
        idle(0); idle(0);
        check_eq("t4_one_redirect", n_redirects - rd_base, 1);
        idle(12'h341); check_eq("t4_mepc", last_rdata, 32'h400);
        idle(12'h300); check_eq("t4_mstatus", last_rdata, 32'h80);

        // 6: reset during first drain cycle
        rd_base = n_redirects;
        step(0, 1, 32'h3, 32'h500, 32'h55, 0, 0, 12'h0, '0);
        step(1, 0, '0, '0, '0, 0, 0, 12'h0, '0);
        idle(12'h305);
        check_eq("t6_outputs", {28'b0, last_flush, last_stall, last_rv, 1'b0}, 32'h0);
        check_eq("t6_mtvec", last_rdata, 32'h4);
        idle(12'h341); check_eq("t6_mepc", last_rdata, 32'h0);
        idle(12'h342); check_eq("t6_mcause", last_rdata, 32'h0);
        idle(0); idle(0);
        check_eq("t6_no_redirect", n_redirects - rd_base, 0);

        // Randomized traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 6))
                0: ra = 12'h300;
                1: ra = 12'h305;
                2: ra = 12'h341;
                3: ra = 12'h342;
                4: ra = 12'h343;
                5: ra = 12'h000;
                default: ra = 12'($urandom);
            endcase
            rpc = $urandom;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0), $urandom, rpc, $urandom,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
